// File: rtl/sysbus_line_reader.sv
// sysbus_line_reader
//
// Fetches one cache line over the Sysbus request/response channels and
// presents it to a client as a single wide word.
//
//   clk, reset           single rising-edge clock, synchronous active-high reset
//   fill_valid/ready     client line-fill request, fill_addr is any byte address
//                        inside the wanted line
//   line_valid/ready     assembled line out: line_data (beat i at slot i) and
//                        line_addr (line-aligned address)
//   bus_req*             read request to the bus: address, tag, valid (reqcyc),
//                        accept (reqack)
//   bus_resp*            response beats: data, tag, valid (respcyc),
//                        accept (respack)
//
// Handshakes: a transfer happens on a rising edge where the producer's valid
// and the consumer's ready/ack are both high. A producer holds valid and its
// payload stable until that edge. bus_respack is the one combinational ready:
// it acknowledges only beats whose tag is a read response to the request in
// flight, so stray beats on the shared bus are ignored.
module sysbus_line_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int BEATS      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  // client fill request
  input  logic                         fill_valid,
  input  logic [63:0]                  fill_addr,
  output logic                         fill_ready,
  // assembled line
  output logic                         line_valid,
  input  logic                         line_ready,
  output logic [DATA_WIDTH*BEATS-1:0]  line_data,
  output logic [63:0]                  line_addr,
  // bus request channel
  output logic [63:0]                  bus_req,
  output logic [TAG_WIDTH-1:0]         bus_reqtag,
  output logic                         bus_reqcyc,
  input  logic                         bus_reqack,
  // bus response channel
  input  logic [DATA_WIDTH-1:0]        bus_resp,
  input  logic [TAG_WIDTH-1:0]         bus_resptag,
  input  logic                         bus_respcyc,
  output logic                         bus_respack
);

  localparam int LINE_W     = DATA_WIDTH * BEATS;
  localparam int LINE_BYTES = (DATA_WIDTH / 8) * BEATS;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Clears the byte-offset bits so the request is line aligned.
  localparam logic [63:0] LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);

  localparam logic       DIR_READ    = 1'b1;
  localparam logic [3:0] TYPE_MEMORY = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         id_q;      // id for the next request
  logic [7:0]         issued_q;  // id of the request currently in flight
  logic [63:0]        addr_q;
  logic [LINE_W-1:0]  line_q;

  logic [63:0]        addr_d;
  logic [7:0]         id_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               cnt_last;
  logic               resp_match;

  // The type field of a response tag is not checked: a matching id and the
  // read direction identify our beat.
  logic [TAG_WIDTH-10:0] unused_resp_type;
  assign unused_resp_type = bus_resptag[TAG_WIDTH-2:8];

  assign addr_d   = fill_addr & LINE_MASK;
  assign id_d     = id_q + 8'd1;          // wraps 255 -> 0
  assign cnt_last = (cnt_q == CNT_W'(BEATS - 1));
  assign cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;

  assign resp_match = bus_respcyc
                   && (bus_resptag[7:0] == issued_q)
                   && (bus_resptag[TAG_WIDTH-1] == DIR_READ);

  // Outputs decode the state register. Reset gates them so nothing is
  // offered or acknowledged while reset is held, including the first cycle.
  assign fill_ready  = !reset && (state_q == IDLE);
  assign bus_reqcyc  = !reset && (state_q == REQ);
  assign line_valid  = !reset && (state_q == DONE);
  assign bus_respack = !reset && (state_q == RESP) && resp_match;

  assign bus_req    = bus_reqcyc ? addr_q : 64'd0;
  assign bus_reqtag = bus_reqcyc ? TAG_WIDTH'({DIR_READ, TYPE_MEMORY, id_q})
                                 : '0;

  assign line_data = line_q;
  assign line_addr = addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      id_q     <= 8'd0;
      issued_q <= 8'd0;
      addr_q   <= 64'd0;
      line_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fill_valid) begin
            addr_q  <= addr_d;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus_reqack) begin
            issued_q <= id_q;
            id_q     <= id_d;
            cnt_q    <= '0;
            state_q  <= RESP;
          end
        end
        RESP: begin
          // Beats can arrive with gaps and interleaved with other traffic;
          // only acknowledged beats advance the slot counter.
          if (bus_respack) begin
            line_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] <= bus_resp;
            cnt_q <= cnt_d;
            if (cnt_last) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (line_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_line_reader.sv
// Directed testbench for sysbus_line_reader.
// Inputs change 1 ns after a rising edge; outputs are sampled 1-2 ns after it.
module tb_sysbus_line_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         fill_valid;
  logic [63:0]  fill_addr;
  logic         fill_ready;
  logic         line_valid;
  logic         line_ready;
  logic [511:0] line_data;
  logic [63:0]  line_addr;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqcyc;
  logic         bus_reqack;
  logic [63:0]  bus_resp;
  logic [12:0]  bus_resptag;
  logic         bus_respcyc;
  logic         bus_respack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sysbus_line_reader dut (
    .clk         (clk),
    .reset       (reset),
    .fill_valid  (fill_valid),
    .fill_addr   (fill_addr),
    .fill_ready  (fill_ready),
    .line_valid  (line_valid),
    .line_ready  (line_ready),
    .line_data   (line_data),
    .line_addr   (line_addr),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqcyc  (bus_reqcyc),
    .bus_reqack  (bus_reqack),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respcyc (bus_respcyc),
    .bus_respack (bus_respack)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the test sequence ended");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [63:0] a);
    fill_valid = 1'b1;
    fill_addr  = a;
    tick();
    fill_valid = 1'b0;
    fill_addr  = 64'd0;
  endtask

  task automatic grant_req;
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [12:0] t,
                            output logic ack);
    bus_respcyc = 1'b1;
    bus_resp    = d;
    bus_resptag = t;
    #1;
    ack = bus_respack;
    tick();
    bus_respcyc = 1'b0;
    bus_resp    = 64'd0;
    bus_resptag = 13'd0;
  endtask

  task automatic consume;
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
  endtask

  // Reference line: slot i holds base+i.
  function automatic logic [511:0] make_line(input logic [63:0] base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
    return l;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    bus_respcyc = 1'b1;
    bus_resptag = 13'h1000;
    tick();
    tick();
    total++; if (fill_ready !== 1'b0) begin bad++; $display("FAIL rst_fill_ready got=%b exp=0", fill_ready); end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL rst_line_valid got=%b exp=0", line_valid); end
    total++; if (bus_reqcyc !== 1'b0) begin bad++; $display("FAIL rst_reqcyc got=%b exp=0", bus_reqcyc); end
    total++; if (bus_respack !== 1'b0) begin bad++; $display("FAIL rst_respack got=%b exp=0", bus_respack); end
    total++; if (bus_req !== 64'd0) begin bad++; $display("FAIL rst_req got=%h exp=0", bus_req); end
    total++; if (bus_reqtag !== 13'd0) begin bad++; $display("FAIL rst_reqtag got=%h exp=0", bus_reqtag); end
    total++; if (line_data !== 512'd0) begin bad++; $display("FAIL rst_line_data got=%h exp=0", line_data); end
    total++; if (line_addr !== 64'd0) begin bad++; $display("FAIL rst_line_addr got=%h exp=0", line_addr); end
    bus_respcyc = 1'b0;
    bus_resptag = 13'd0;
    reset = 1'b0;
    #1;
    total++; if (fill_ready !== 1'b1) begin bad++; $display("FAIL rst_release_fill_ready got=%b exp=1", fill_ready); end
    tick();
  endtask

  task automatic test_basic_fill;
    logic ack;
    logic [511:0] exp_line;
    exp_line = make_line(64'hA0);
    fill_valid = 1'b1;
    fill_addr  = 64'h1234;
    #1;
    total++; if (fill_ready !== 1'b1) begin bad++; $display("FAIL basic_fill_ready got=%b exp=1", fill_ready); end
    tick();
    fill_valid = 1'b0;
    fill_addr  = 64'd0;
    #1;
    total++; if (bus_reqcyc !== 1'b1) begin bad++; $display("FAIL basic_reqcyc got=%b exp=1", bus_reqcyc); end
    total++; if (bus_req !== 64'h1200) begin bad++; $display("FAIL basic_req got=%h exp=1200", bus_req); end
    total++; if (bus_reqtag !== 13'h1100) begin bad++; $display("FAIL basic_reqtag got=%h exp=1100", bus_reqtag); end
    total++; if (fill_ready !== 1'b0) begin bad++; $display("FAIL basic_busy_fill_ready got=%b exp=0", fill_ready); end
    grant_req();
    total++; if (bus_reqcyc !== 1'b0) begin bad++; $display("FAIL basic_reqcyc_drop got=%b exp=0", bus_reqcyc); end
    for (int i = 0; i < 8; i++) begin
      total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL basic_early_line_valid beat=%0d got=%b exp=0", i, line_valid); end
      drive_beat(64'hA0 + 64'(i), 13'h1100, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL basic_ack beat=%0d got=%b exp=1", i, ack); end
    end
    total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL basic_line_valid got=%b exp=1", line_valid); end
    total++; if (line_data !== exp_line) begin bad++; $display("FAIL basic_line_data got=%h exp=%h", line_data, exp_line); end
    total++; if (line_addr !== 64'h1200) begin bad++; $display("FAIL basic_line_addr got=%h exp=1200", line_addr); end
    bus_respcyc = 1'b1;
    bus_resptag = 13'h1100;
    #1;
    total++; if (bus_respack !== 1'b0) begin bad++; $display("FAIL basic_done_respack got=%b exp=0", bus_respack); end
    bus_respcyc = 1'b0;
    bus_resptag = 13'd0;
    line_ready  = 1'b1;
    #1;
    total++; if (fill_ready !== 1'b0) begin bad++; $display("FAIL basic_same_cycle_refill got=%b exp=0", fill_ready); end
    tick();
    line_ready = 1'b0;
    total++; if (fill_ready !== 1'b1) begin bad++; $display("FAIL basic_back_idle got=%b exp=1", fill_ready); end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL basic_line_valid_drop got=%b exp=0", line_valid); end
  endtask

  task automatic test_delayed_ack;
    logic ack;
    int misses;
    logic [511:0] exp_line;
    exp_line = make_line(64'hB0);
    misses = 0;
    do_accept(64'h8040);
    for (int k = 0; k < 6; k++) begin
      bus_respcyc = 1'b1;
      bus_resptag = 13'h1101;
      #1;
      total++;
      if ({bus_reqcyc, bus_req, bus_reqtag, bus_respack} !== {1'b1, 64'h8040, 13'h1101, 1'b0}) begin
        bad++;
        $display("FAIL delay_hold cycle=%0d got=%b/%h/%h/%b exp=1/8040/1101/0", k, bus_reqcyc, bus_req, bus_reqtag, bus_respack);
      end
      if (k == 5) bus_reqack = 1'b1;
      tick();
    end
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resptag = 13'd0;
    for (int i = 0; i < 8; i++) begin
      drive_beat(64'hB0 + 64'(i), 13'h1101, ack);
      if (ack !== 1'b1) misses++;
    end
    total++; if (misses !== 0) begin bad++; $display("FAIL delay_acks got=%0d exp=0 missed", misses); end
    total++; if (line_data !== exp_line) begin bad++; $display("FAIL delay_line_data got=%h exp=%h", line_data, exp_line); end
    total++; if (line_addr !== 64'h8040) begin bad++; $display("FAIL delay_line_addr got=%h exp=8040", line_addr); end
    consume();
  endtask

  task automatic test_gapped_foreign;
    // 0 idle, 1 foreign id 0x55, 2 own beat, 3 own id but write direction
    logic [1:0] seq [16] = '{2, 0, 1, 2, 2, 3, 0, 2, 1, 2, 0, 0, 2, 1, 2, 2};
    logic ack;
    logic [63:0] d;
    logic [12:0] t;
    logic exp_ack;
    int r;
    logic [511:0] exp_line;
    exp_line = make_line(64'hC0);
    r = 0;
    do_accept(64'h4000_0000_0000_0FFF);
    grant_req();
    for (int k = 0; k < 16; k++) begin
      total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL gap_early_line_valid step=%0d got=%b exp=0", k, line_valid); end
      if (seq[k] == 2'd0) begin
        tick();
      end else begin
        case (seq[k])
          2'd1:    begin d = 64'hDEAD_0000_0000_0000 + 64'(k); t = 13'h1155; exp_ack = 1'b0; end
          2'd3:    begin d = 64'hBAD0_0000_0000_0000 + 64'(k); t = 13'h0102; exp_ack = 1'b0; end
          default: begin d = 64'hC0 + 64'(r);                  t = 13'h1102; exp_ack = 1'b1; r++; end
        endcase
        drive_beat(d, t, ack);
        total++; if (ack !== exp_ack) begin bad++; $display("FAIL gap_ack step=%0d got=%b exp=%b", k, ack, exp_ack); end
      end
    end
    total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL gap_line_valid got=%b exp=1", line_valid); end
    total++; if (line_data !== exp_line) begin bad++; $display("FAIL gap_line_data got=%h exp=%h", line_data, exp_line); end
    total++; if (line_addr !== 64'h4000_0000_0000_0FC0) begin bad++; $display("FAIL gap_line_addr got=%h exp=40000000000000fc0", line_addr); end
    consume();
  endtask

  task automatic test_backpressure;
    logic ack;
    int misses;
    logic [511:0] exp_line;
    exp_line = make_line(64'hD0);
    misses = 0;
    do_accept(64'h2_0000_0047);
    #1;
    total++; if (bus_reqtag !== 13'h1103) begin bad++; $display("FAIL bp_reqtag got=%h exp=1103", bus_reqtag); end
    grant_req();
    for (int i = 0; i < 8; i++) begin
      drive_beat(64'hD0 + 64'(i), 13'h1103, ack);
      if (ack !== 1'b1) misses++;
    end
    total++; if (misses !== 0) begin bad++; $display("FAIL bp_acks got=%0d exp=0 missed", misses); end
    fill_valid = 1'b1;
    fill_addr  = 64'h9999;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if ({line_valid, fill_ready} !== 2'b10) begin bad++; $display("FAIL bp_hold cycle=%0d got=%b%b exp=10", k, line_valid, fill_ready); end
      total++; if (line_data !== exp_line || line_addr !== 64'h2_0000_0040) begin bad++; $display("FAIL bp_stable cycle=%0d got=%h/%h exp=%h/200000040", k, line_data, line_addr, exp_line); end
      tick();
    end
    fill_valid = 1'b0;
    fill_addr  = 64'd0;
    consume();
    total++; if ({fill_ready, line_valid, bus_reqcyc} !== 3'b100) begin bad++; $display("FAIL bp_release got=%b%b%b exp=100", fill_ready, line_valid, bus_reqcyc); end
  endtask

  task automatic test_id_wrap;
    logic ack;
    int misses;
    int tag_err;
    logic [12:0] t;
    misses  = 0;
    tag_err = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 256; n++) begin
      t = {5'b10001, 8'(n)};
      do_accept(64'(n) * 64'd64);
      if (bus_reqtag !== t) tag_err++;
      if (n == 255) begin
        total++; if (bus_reqtag !== 13'h11FF) begin bad++; $display("FAIL wrap_tag_255 got=%h exp=11ff", bus_reqtag); end
      end
      grant_req();
      for (int i = 0; i < 8; i++) begin
        drive_beat(64'(n), t, ack);
        if (ack !== 1'b1) misses++;
      end
      consume();
    end
    total++; if (tag_err !== 0) begin bad++; $display("FAIL wrap_tags got=%0d exp=0 wrong", tag_err); end
    total++; if (misses !== 0) begin bad++; $display("FAIL wrap_acks got=%0d exp=0 missed", misses); end
    do_accept(64'h100);
    total++; if (bus_reqtag !== 13'h1100) begin bad++; $display("FAIL wrap_tag_257 got=%h exp=1100", bus_reqtag); end
    grant_req();
    for (int i = 0; i < 8; i++) drive_beat(64'd0, 13'h1100, ack);
    consume();
  endtask

  task automatic test_reset_mid;
    logic ack;
    int misses;
    int stray;
    logic [511:0] exp_line;
    exp_line = make_line(64'hF0);
    misses = 0;
    stray  = 0;
    do_accept(64'h7000);
    total++; if (bus_reqtag !== 13'h1101) begin bad++; $display("FAIL rmid_reqtag got=%h exp=1101", bus_reqtag); end
    grant_req();
    for (int i = 0; i < 4; i++) begin
      drive_beat(64'hE0 + 64'(i), 13'h1101, ack);
      if (ack !== 1'b1) misses++;
    end
    total++; if (misses !== 0) begin bad++; $display("FAIL rmid_acks got=%0d exp=0 missed", misses); end
    bus_respcyc = 1'b1;
    bus_resptag = 13'h1101;
    bus_resp    = 64'hEE;
    reset       = 1'b1;
    #1;
    total++; if (bus_respack !== 1'b0) begin bad++; $display("FAIL rmid_respack_in_reset got=%b exp=0", bus_respack); end
    tick();
    total++;
    if ({fill_ready, line_valid, bus_reqcyc, bus_respack} !== 4'b0000) begin
      bad++;
      $display("FAIL rmid_ctrl got=%b%b%b%b exp=0000", fill_ready, line_valid, bus_reqcyc, bus_respack);
    end
    total++; if (bus_req !== 64'd0 || bus_reqtag !== 13'd0) begin bad++; $display("FAIL rmid_req got=%h/%h exp=0/0", bus_req, bus_reqtag); end
    total++; if (line_data !== 512'd0 || line_addr !== 64'd0) begin bad++; $display("FAIL rmid_line got=%h/%h exp=0/0", line_data, line_addr); end
    reset = 1'b0;
    #1;
    total++; if ({fill_ready, bus_respack} !== 2'b10) begin bad++; $display("FAIL rmid_after got=%b%b exp=10", fill_ready, bus_respack); end
    for (int k = 0; k < 10; k++) begin
      if (line_valid !== 1'b0 || bus_respack !== 1'b0) stray++;
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resptag = 13'd0;
    bus_resp    = 64'd0;
    total++; if (stray !== 0) begin bad++; $display("FAIL rmid_abandon got=%0d exp=0 stray cycles", stray); end
    misses = 0;
    do_accept(64'h1234);
    total++; if (bus_reqtag !== 13'h1100 || bus_req !== 64'h1200) begin bad++; $display("FAIL rmid_fresh_req got=%h/%h exp=1100/1200", bus_reqtag, bus_req); end
    grant_req();
    for (int i = 0; i < 8; i++) begin
      drive_beat(64'hF0 + 64'(i), 13'h1100, ack);
      if (ack !== 1'b1) misses++;
    end
    total++; if (misses !== 0) begin bad++; $display("FAIL rmid_fresh_acks got=%0d exp=0 missed", misses); end
    total++; if (line_valid !== 1'b1 || line_data !== exp_line) begin bad++; $display("FAIL rmid_fresh_line got=%b/%h exp=1/%h", line_valid, line_data, exp_line); end
    consume();
  endtask

  initial begin
    reset       = 1'b1;
    fill_valid  = 1'b0;
    fill_addr   = 64'd0;
    line_ready  = 1'b0;
    bus_reqack  = 1'b0;
    bus_resp    = 64'd0;
    bus_resptag = 13'd0;
    bus_respcyc = 1'b0;
    test_reset();
    test_basic_fill();
    test_delayed_ack();
    test_gapped_foreign();
    test_backpressure();
    test_id_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysbus_line_reader.md
SYSBUS_LINE_READER -- requirements
Module: sysbus_line_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the bus beat width in bits.
REQ-002 Parameter TAG_WIDTH, default 13, SHALL set the tag width; layout {dir[12], type[11:8], id[7:0]}.
REQ-003 Parameter BEATS, default 8, SHALL set the beats per line; line width = DATA_WIDTH*BEATS (512).
REQ-004 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  fill_valid  in  1  client line-fill request
  fill_addr  in  64  fill byte address
  fill_ready  out  1  request accepted when fill_valid&&fill_ready
  line_valid  out  1  assembled line available
  line_ready  in  1  client consumes line
  line_data  out  512  assembled line, beat i at [64i+63:64i]
  line_addr  out  64  line-aligned address of line_data
  bus_req  out  64  request address to Sysbus Bottom
  bus_reqtag  out  13  request tag
  bus_reqcyc  out  1  request valid
  bus_reqack  in  1  bus accepted request
  bus_resp  in  64  response beat
  bus_resptag  in  13  response tag
  bus_respcyc  in  1  response beat valid
  bus_respack  out  1  beat accepted
REQ-005 Clocking and reset SHALL be one clock (clk); reset is synchronous and active-high.

Function
REQ-006 FSM states SHALL be IDLE, REQ, RESP, DONE; reset state IDLE.
REQ-007 IDLE: fill_ready=1; on fill_valid, latch {fill_addr[63:6],6'b0} and go to REQ next cycle.
REQ-008 REQ: bus_reqcyc=1, bus_req=latched address, bus_reqtag={1'b1 (READ),4'b0001 (MEMORY),id}; all held stable until bus_reqack is sampled high.
REQ-009 REQ with bus_reqack=1 at a rising edge SHALL go to RESP, beat counter=0, bus_reqcyc=0 next cycle.
REQ-010 id SHALL be an 8-bit counter, reset 0, incremented on REQ->RESP, wrapping 255->0.
REQ-011 RESP: bus_respack SHALL be combinational = bus_respcyc && bus_resptag[7:0]==issued id && bus_resptag[12]==1.
REQ-012 Each acked beat SHALL be written to line_data slot [counter], counter incremented; beats may be non-consecutive.
REQ-013 Beat with non-matching tag SHALL be neither acked nor stored; counter unchanged.
REQ-014 On acking beat BEATS-1, go to DONE; counter wraps to 0.
REQ-015 DONE: line_valid=1, line_data/line_addr stable; on line_ready go to IDLE.
REQ-016 bus_respack SHALL be 0 in IDLE, REQ, DONE regardless of bus_respcyc.
REQ-017 fill_ready SHALL be 0 outside IDLE; one outstanding request maximum.
REQ-018 Minimum latency: accept at edge N; reqcyc cycle N+1; reqack at N+1 gives beats N+2..N+9; line_valid from cycle N+10.
REQ-019 line_valid and line_ready both high at an edge SHALL return to IDLE; fill_ready is 1 the following cycle (no same-cycle refill).

Reset
REQ-020 reset high at a rising edge SHALL force IDLE, counter=0, id=0, line_data=0, line_addr=0.
REQ-021 While reset is high, fill_ready, line_valid, bus_reqcyc, bus_respack SHALL be 0, and bus_req and bus_reqtag SHALL be 0.
REQ-022 Reset mid-transaction SHALL abandon it silently: no further acks, no line_valid.

Verification
REQ-023 Basic fill: fill_addr=0x1234 -> bus_req=0x1200, bus_reqtag=0x1100; beats 0..7 = 0xA0..0xA7 -> line_data slot i = 0xA0+i, line_addr=0x1200.
REQ-024 Delayed ack: reqack withheld 5 cycles -> reqcyc/req/reqtag constant for 6 cycles, no respack before ack.
REQ-025 Gapped/foreign beats: idle cycles and tag id=0x55 beats interleaved -> foreign beats unacked and unstored, line correct.
REQ-026 Back-pressure/id: line_ready low 4 cycles -> line_valid held, fill_ready=0; second fill tag=0x1101; 256 fills -> id wraps to 0x1100.
REQ-027 Reset after beat 3 -> next cycle all outputs 0; fresh fill afterward completes with tag 0x1100.
